// File: rtl/pair_hsmooth_pkg.sv
// Shared types and widths for the two-pixel-per-clock horizontal smoother.
// Channel index 0 = R, 1 = G, 2 = B inside an rgb_t.
package pair_hsmooth_pkg;

  localparam int PIX_W = 8;
  localparam int SUM_W = 10;
  localparam int NCH   = 3;

  typedef logic [PIX_W-1:0]           pix_t;
  typedef logic [NCH-1:0][PIX_W-1:0]  rgb_t;

  // Counter width that stays legal for a range of a single value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pair_hsmooth_tap3.sv
// Combinational [1 2 1]/4 kernel with rounding for one channel of one pixel.
// The worst-case sum is 1022, so the 10-bit sum never overflows.
module hsmooth_tap3
  import pair_hsmooth_pkg::*;
(
  input  pix_t p_prev,
  input  pix_t p_cur,
  input  pix_t p_next,
  output pix_t y
);

  logic [SUM_W-1:0] sum;

  assign sum = SUM_W'(p_prev) + {1'b0, p_cur, 1'b0} + SUM_W'(p_next) + SUM_W'(2);
  assign y   = sum[SUM_W-1:2];

endmodule

// File: rtl/pair_hsmooth.sv
// Streaming 3-tap horizontal smoother on a two-pixel-per-clock RGB stream,
// with edge replication at row boundaries and a sticky frame-done flag.
module pair_hsmooth
  import pair_hsmooth_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             VSYNC,
  input  logic             HSYNC,
  input  logic [PIX_W-1:0] DATA_R0,
  input  logic [PIX_W-1:0] DATA_G0,
  input  logic [PIX_W-1:0] DATA_B0,
  input  logic [PIX_W-1:0] DATA_R1,
  input  logic [PIX_W-1:0] DATA_G1,
  input  logic [PIX_W-1:0] DATA_B1,
  output logic             VSYNC_O,
  output logic             HSYNC_O,
  output logic [PIX_W-1:0] DATA_R0_O,
  output logic [PIX_W-1:0] DATA_G0_O,
  output logic [PIX_W-1:0] DATA_B0_O,
  output logic [PIX_W-1:0] DATA_R1_O,
  output logic [PIX_W-1:0] DATA_G1_O,
  output logic [PIX_W-1:0] DATA_B1_O,
  output logic             ctrl_done
);

  localparam int PAIRS = WIDTH / 2;
  localparam int COL_W = cnt_w(PAIRS);
  localparam int ROW_W = cnt_w(HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PAIRS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  rgb_t in_p0, in_p1;
  rgb_t cur_p0_reg, cur_p1_reg, prev_reg;
  rgb_t out_p0_reg, out_p1_reg;
  rgb_t y_p0, y_p1, next_pix;
  logic cur_v_reg, cur_last_reg, cur_flast_reg;
  logic hsync_o_reg, vsync_o_reg, done_reg;
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic emit_last, emit, col_wrap;

  assign in_p0 = {DATA_B0, DATA_G0, DATA_R0};
  assign in_p1 = {DATA_B1, DATA_G1, DATA_R1};

  // The row's last pair closes on its own right neighbour so that a
  // back-to-back pair from the next row is never mixed in.
  assign emit_last = cur_v_reg & cur_last_reg;
  assign emit      = emit_last | (cur_v_reg & HSYNC);
  assign next_pix  = emit_last ? cur_p1_reg : in_p0;
  assign col_wrap  = (col_reg == COL_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      hsmooth_tap3 u_tap_p0 (
        .p_prev (prev_reg[gi]),
        .p_cur  (cur_p0_reg[gi]),
        .p_next (cur_p1_reg[gi]),
        .y      (y_p0[gi])
      );
      hsmooth_tap3 u_tap_p1 (
        .p_prev (cur_p0_reg[gi]),
        .p_cur  (cur_p1_reg[gi]),
        .p_next (next_pix[gi]),
        .y      (y_p1[gi])
      );
    end
  endgenerate

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cur_p0_reg    <= '0;
      cur_p1_reg    <= '0;
      prev_reg      <= '0;
      out_p0_reg    <= '0;
      out_p1_reg    <= '0;
      cur_v_reg     <= 1'b0;
      cur_last_reg  <= 1'b0;
      cur_flast_reg <= 1'b0;
      hsync_o_reg   <= 1'b0;
      vsync_o_reg   <= 1'b0;
      done_reg      <= 1'b0;
      col_reg       <= '0;
      row_reg       <= '0;
    end else begin
      vsync_o_reg <= VSYNC;
      hsync_o_reg <= emit;
      if (emit) begin
        out_p0_reg <= y_p0;
        out_p1_reg <= y_p1;
      end

      // Setting wins if a new frame's first pair arrives on the same edge.
      if (emit_last && cur_flast_reg)
        done_reg <= 1'b1;
      else if (HSYNC)
        done_reg <= 1'b0;

      if (HSYNC) begin
        cur_p0_reg    <= in_p0;
        cur_p1_reg    <= in_p1;
        cur_v_reg     <= 1'b1;
        cur_last_reg  <= col_wrap;
        cur_flast_reg <= col_wrap && (row_reg == ROW_LAST);
        prev_reg      <= (col_reg == '0) ? in_p0 : cur_p1_reg;
        col_reg       <= col_wrap ? '0 : col_reg + 1'b1;
        if (col_wrap)
          row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
      end else if (emit_last) begin
        cur_v_reg <= 1'b0;
      end
    end
  end

  assign VSYNC_O   = vsync_o_reg;
  assign HSYNC_O   = hsync_o_reg;
  assign ctrl_done = done_reg;
  assign DATA_R0_O = out_p0_reg[0];
  assign DATA_G0_O = out_p0_reg[1];
  assign DATA_B0_O = out_p0_reg[2];
  assign DATA_R1_O = out_p1_reg[0];
  assign DATA_G1_O = out_p1_reg[1];
  assign DATA_B1_O = out_p1_reg[2];

endmodule

// File: tb/tb_pair_hsmooth.sv
// Directed bench for pair_hsmooth on a small 8x2 frame.
module tb_pair_hsmooth;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       VSYNC = 1'b0;
  logic       HSYNC = 1'b0;
  logic [7:0] DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
  logic [7:0] DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
  logic       VSYNC_O, HSYNC_O, ctrl_done;
  logic [7:0] DATA_R0_O, DATA_G0_O, DATA_B0_O, DATA_R1_O, DATA_G1_O, DATA_B1_O;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [47:0] cap_q[$];
  int          cap_cyc[$];
  int          exp_ramp[8] = '{1, 4, 8, 12, 16, 20, 24, 27};

  pair_hsmooth #(.WIDTH(8), .HEIGHT(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .VSYNC_O(VSYNC_O), .HSYNC_O(HSYNC_O),
    .DATA_R0_O(DATA_R0_O), .DATA_G0_O(DATA_G0_O), .DATA_B0_O(DATA_B0_O),
    .DATA_R1_O(DATA_R1_O), .DATA_G1_O(DATA_G1_O), .DATA_B1_O(DATA_B1_O),
    .ctrl_done(ctrl_done)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc++;

  // Capture every emitted pair, away from the active edge.
  always @(negedge HCLK) begin
    if (HSYNC_O) begin
      cap_q.push_back({DATA_R0_O, DATA_G0_O, DATA_B0_O, DATA_R1_O, DATA_G1_O, DATA_B1_O});
      cap_cyc.push_back(cyc);
    end
  end

  function automatic logic [47:0] pk(input int r0, g0, b0, r1, g1, b1);
    return {r0[7:0], g0[7:0], b0[7:0], r1[7:0], g1[7:0], b1[7:0]};
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input int r0, g0, b0, r1, g1, b1);
    DATA_R0 = r0[7:0]; DATA_G0 = g0[7:0]; DATA_B0 = b0[7:0];
    DATA_R1 = r1[7:0]; DATA_G1 = g1[7:0]; DATA_B1 = b1[7:0];
    HSYNC = 1'b1;
    @(posedge HCLK); #1;
    HSYNC = 1'b0;
  endtask

  task automatic idle(input int n);
    HSYNC = 1'b0;
    repeat (n) begin @(posedge HCLK); #1; end
  endtask

  task automatic push_flat_row(input int v);
    for (int k = 0; k < 4; k++) push(v, v, v, v, v, v);
  endtask

  task automatic check_flat(input string tag, input int first, input int n, input int v);
    for (int k = first; k < first + n; k++)
      check(tag, (k < cap_q.size()) ? cap_q[k] : 48'hx, pk(v, v, v, v, v, v));
  endtask

  task automatic check_ramp(input string tag);
    check({tag, "_cnt"}, 48'(cap_q.size()), 48'd4);
    for (int k = 0; k < 4; k++)
      check(tag, (k < cap_q.size()) ? cap_q[k] : 48'hx,
            pk(exp_ramp[2*k], 0, 0, exp_ramp[2*k+1], 0, 0));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_hsync", 48'(HSYNC_O), 48'd0);
    check("rst_vsync", 48'(VSYNC_O), 48'd0);
    check("rst_done", 48'(ctrl_done), 48'd0);
    check("rst_data", {DATA_R0_O, DATA_G0_O, DATA_B0_O, DATA_R1_O, DATA_G1_O, DATA_B1_O}, 48'd0);
    HRESETn = 1'b1;
    VSYNC = 1'b1;
    idle(1);
    check("vsync_dly", 48'(VSYNC_O), 48'd1);
    VSYNC = 1'b0;

    // Flat field, full frame, back-to-back rows
    cap_q.delete(); cap_cyc.delete();
    push_flat_row(100);
    push_flat_row(100);
    check("flat_done_lag", 48'(ctrl_done), 48'd0);
    idle(1);
    check("flat_done", 48'(ctrl_done), 48'd1);
    idle(2);
    check("flat_cnt", 48'(cap_q.size()), 48'd8);
    check_flat("flat_val", 0, 8, 100);

    // Ramp row; first accepted pair of the new frame clears done
    cap_q.delete(); cap_cyc.delete();
    push(0, 0, 0, 4, 0, 0);
    check("done_clear", 48'(ctrl_done), 48'd0);
    for (int k = 1; k < 4; k++) push(8*k, 0, 0, 8*k + 4, 0, 0);
    idle(3);
    check_ramp("ramp");

    // Same ramp with a two-cycle gap mid-row
    cap_q.delete(); cap_cyc.delete();
    push(0, 0, 0, 4, 0, 0);
    push(8, 0, 0, 12, 0, 0);
    check("gap_emit0", 48'(HSYNC_O), 48'd1);
    idle(1);
    check("gap_hold1", 48'(HSYNC_O), 48'd0);
    idle(1);
    check("gap_hold2", 48'(HSYNC_O), 48'd0);
    push(16, 0, 0, 20, 0, 0);
    check("gap_emit1", 48'(HSYNC_O), 48'd1);
    push(24, 0, 0, 28, 0, 0);
    idle(3);
    check_ramp("gap");
    check("gap_done", 48'(ctrl_done), 48'd1);

    // Back-to-back 0 then 255 rows: no cross-row mixing, no output gap
    cap_q.delete(); cap_cyc.delete();
    push_flat_row(0);
    push_flat_row(255);
    idle(3);
    check("b2b_cnt", 48'(cap_q.size()), 48'd8);
    check_flat("b2b_row0", 0, 4, 0);
    check_flat("b2b_row1", 4, 4, 255);
    for (int k = 1; k < 8; k++)
      check("b2b_nogap", 48'((k < cap_cyc.size()) ? cap_cyc[k] - cap_cyc[k-1] : -1), 48'd1);
    check("b2b_done", 48'(ctrl_done), 48'd1);

    // Asynchronous reset in the middle of a row
    push(50, 50, 50, 50, 50, 50);
    push(50, 50, 50, 50, 50, 50);
    #2 HRESETn = 1'b0;
    #1;
    check("arst_hsync", 48'(HSYNC_O), 48'd0);
    check("arst_data", {DATA_R0_O, DATA_G0_O, DATA_B0_O, DATA_R1_O, DATA_G1_O, DATA_B1_O}, 48'd0);
    check("arst_done", 48'(ctrl_done), 48'd0);
    @(posedge HCLK); #3;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    cap_q.delete(); cap_cyc.delete();
    for (int k = 0; k < 4; k++) push(8*k, 0, 0, 8*k + 4, 0, 0);
    idle(3);
    check_ramp("post_rst");
    check("post_rst_done", 48'(ctrl_done), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
